// File: rtl/led_pattern_gen.sv
// LED animation engine: prescaled step tick drives bounce / rotate / bar / binary patterns.
// Optional PWM dimming stage is built when LED_PATTERN_PWM_EN is defined.
module led_pattern_gen #(
  parameter int N_LEDS   = 8,
  parameter int TICK_DIV = 6000000
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              EN,
  input  logic [1:0]        MODE,
`ifdef LED_PATTERN_PWM_EN
  input  logic [3:0]        BRIGHT,
`endif
  output logic [N_LEDS-1:0] LEDS,
  output logic              TICK,
  output logic              CYCLE
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PW = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;

  localparam logic [CW-1:0]     CNT_MAX  = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0]     CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]     CNT_ONE  = CW'(1'b1);
  localparam logic [PW-1:0]     POS_MAX  = PW'(N_LEDS - 1);
  localparam logic [PW-1:0]     POS_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0]     POS_ONE  = PW'(1'b1);
  localparam logic [N_LEDS-1:0] BIN_ONE  = N_LEDS'(1'b1);
  localparam logic [N_LEDS-1:0] BIN_ALL  = {N_LEDS{1'b1}};

  typedef enum logic [1:0] {
    MODE_BOUNCE = 2'd0,
    MODE_ROTATE = 2'd1,
    MODE_BAR    = 2'd2,
    MODE_BINARY = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  logic [CW-1:0]     cnt_r;
  logic              step_s;
  logic [PW-1:0]     pos_r;
  logic [PW-1:0]     pos_n;
  dir_t              dir_r;
  dir_t              dir_n;
  logic [N_LEDS-1:0] bin_r;
  logic [N_LEDS-1:0] bin_n;
  logic              start_n;
  mode_t             amode_r;
  mode_t             mode_in_s;
  logic [N_LEDS-1:0] pat_r;
  logic              tick_r;
  logic              cycle_r;

  // LED image for a given mode and step state.
  function automatic logic [N_LEDS-1:0] pattern_of(
    input mode_t             mode,
    input logic [PW-1:0]     pos,
    input logic [N_LEDS-1:0] bin
  );
    logic [N_LEDS-1:0] p;
    p = BIN_ONE;
    case (mode)
      MODE_BOUNCE, MODE_ROTATE: p = BIN_ONE << pos;
      MODE_BAR: begin
        for (int i = 0; i < N_LEDS; i++) begin
          p[i] = (PW'(i) <= pos);
        end
      end
      MODE_BINARY: p = bin;
      default:     p = BIN_ONE;
    endcase
    return p;
  endfunction

  // Prescaler: counts only while enabled, wraps at TICK_DIV-1.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      cnt_r <= CNT_ZERO;
    end else if (EN) begin
      if (cnt_r == CNT_MAX) begin
        cnt_r <= CNT_ZERO;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign step_s    = EN && (cnt_r == CNT_MAX);
  assign mode_in_s = mode_t'(MODE);

  // Next step state for the active mode; direction flips as an endpoint is reached.
  always_comb begin
    pos_n   = pos_r;
    dir_n   = dir_r;
    bin_n   = bin_r;
    start_n = 1'b0;
    case (amode_r)
      MODE_BOUNCE, MODE_BAR: begin
        if (dir_r == DIR_UP) begin
          if (pos_r >= POS_MAX) begin
            pos_n = POS_MAX - POS_ONE;
            dir_n = DIR_DOWN;
          end else begin
            pos_n = pos_r + POS_ONE;
            dir_n = (pos_n == POS_MAX) ? DIR_DOWN : DIR_UP;
          end
        end else begin
          if (pos_r == POS_ZERO) begin
            pos_n = POS_ONE;
            dir_n = DIR_UP;
          end else begin
            pos_n = pos_r - POS_ONE;
            dir_n = (pos_n == POS_ZERO) ? DIR_UP : DIR_DOWN;
          end
        end
      end
      MODE_ROTATE: begin
        if (pos_r >= POS_MAX) begin
          pos_n = POS_ZERO;
        end else begin
          pos_n = pos_r + POS_ONE;
        end
        dir_n = DIR_UP;
      end
      MODE_BINARY: begin
        if (bin_r == BIN_ALL) begin
          bin_n = BIN_ONE;
        end else begin
          bin_n = bin_r + BIN_ONE;
        end
      end
      default: begin
        pos_n = POS_ZERO;
        dir_n = DIR_UP;
        bin_n = BIN_ONE;
      end
    endcase
    if (amode_r == MODE_BINARY) begin
      start_n = (bin_n == BIN_ONE);
    end else begin
      start_n = (pos_n == POS_ZERO);
    end
  end

  // Step state machine with registered pattern and strobes; a mode change restarts without advancing.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      amode_r <= MODE_BOUNCE;
      pos_r   <= POS_ZERO;
      dir_r   <= DIR_UP;
      bin_r   <= BIN_ONE;
      pat_r   <= BIN_ONE;
      tick_r  <= 1'b0;
      cycle_r <= 1'b0;
    end else if (step_s) begin
      tick_r <= 1'b1;
      if (mode_in_s != amode_r) begin
        amode_r <= mode_in_s;
        pos_r   <= POS_ZERO;
        dir_r   <= DIR_UP;
        bin_r   <= BIN_ONE;
        pat_r   <= pattern_of(mode_in_s, POS_ZERO, BIN_ONE);
        cycle_r <= 1'b1;
      end else begin
        amode_r <= amode_r;
        pos_r   <= pos_n;
        dir_r   <= dir_n;
        bin_r   <= bin_n;
        pat_r   <= pattern_of(amode_r, pos_n, bin_n);
        cycle_r <= start_n;
      end
    end else begin
      tick_r  <= 1'b0;
      cycle_r <= 1'b0;
    end
  end

  assign TICK  = tick_r;
  assign CYCLE = cycle_r;

`ifdef LED_PATTERN_PWM_EN
  logic [3:0]        pwm_r;
  logic [N_LEDS-1:0] leds_r;

  // Free-running duty counter gates the pattern; duty is (BRIGHT+1)/16.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      pwm_r  <= 4'd0;
      leds_r <= BIN_ONE;
    end else begin
      pwm_r  <= pwm_r + 4'd1;
      leds_r <= pat_r & {N_LEDS{pwm_r <= BRIGHT}};
    end
  end

  assign LEDS = leds_r;
`else
  assign LEDS = pat_r;
`endif

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen at N_LEDS=4, TICK_DIV=4; PWM checks build with LED_PATTERN_PWM_EN.
module tb_led_pattern_gen;

`ifdef LED_PATTERN_PWM_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic       CLK;
  logic       RESETN;
  logic       EN;
  logic [1:0] MODE;
  logic [3:0] LEDS;
  logic       TICK;
  logic       CYCLE;
`ifdef LED_PATTERN_PWM_EN
  logic [3:0] BRIGHT;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int skew     = 0;

  led_pattern_gen #(.N_LEDS(4), .TICK_DIV(4)) dut (
    .CLK    (CLK),
    .RESETN (RESETN),
    .EN     (EN),
    .MODE   (MODE),
`ifdef LED_PATTERN_PWM_EN
    .BRIGHT (BRIGHT),
`endif
    .LEDS   (LEDS),
    .TICK   (TICK),
    .CYCLE  (CYCLE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Runs to the next TICK (bounded); n is edges since the previous tick, 0 on timeout.
  task automatic wait_tick(output int n, output logic [3:0] leds, output logic cyc);
    n   = 0;
    cyc = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge CLK); #1;
      if (TICK === 1'b1) begin
        n   = i + skew;
        cyc = CYCLE;
        break;
      end
    end
    for (int i = 0; i < LAT; i++) begin
      @(posedge CLK); #1;
    end
    leds = LEDS;
    skew = LAT;
  endtask

  task automatic test_reset();
    int n; logic [3:0] l; logic c;
    RESETN = 1'b0; EN = 1'b1; MODE = 2'd0;
    repeat (2) @(posedge CLK);
    #1;
    n_checks++;
    if (LEDS !== 4'b0001 || TICK !== 1'b0 || CYCLE !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: leds=%b tick=%b cycle=%b, expected 0001 0 0", LEDS, TICK, CYCLE);
    end
    @(negedge CLK);
    RESETN = 1'b1;
    skew = 0;
    wait_tick(n, l, c);
    n_checks++;
    if (n !== 4 || l !== 4'b0010 || c !== 1'b0) begin
      n_fail++;
      $display("FAIL first_tick: edges=%0d leds=%b cycle=%b, expected 4 0010 0", n, l, c);
    end
  endtask

  task automatic test_bounce();
    int n; logic [3:0] l; logic c;
    logic [3:0] exp_l [0:5];
    logic       exp_c [0:5];
    exp_l = '{4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    exp_c = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 6; k++) begin
      wait_tick(n, l, c);
      n_checks++;
      if (n !== 4 || l !== exp_l[k] || c !== exp_c[k]) begin
        n_fail++;
        $display("FAIL bounce step %0d: edges=%0d leds=%b cycle=%b, expected 4 %b %b",
                 k, n, l, c, exp_l[k], exp_c[k]);
      end
      if (k == 4) begin
        for (int i = LAT; i < 1; i++) begin
          @(posedge CLK); #1;
        end
        skew = 1;
        n_checks++;
        if (TICK !== 1'b0 || CYCLE !== 1'b0) begin
          n_fail++;
          $display("FAIL strobe_width: tick=%b cycle=%b one cycle after pulse, expected 0 0", TICK, CYCLE);
        end
      end
    end
  endtask

  task automatic test_rotate();
    int n; logic [3:0] l; logic c;
    logic [3:0] exp_l [0:4];
    logic       exp_c [0:4];
    exp_l = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_c = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    MODE = 2'd1;
    for (int k = 0; k < 5; k++) begin
      wait_tick(n, l, c);
      n_checks++;
      if (n !== 4 || l !== exp_l[k] || c !== exp_c[k]) begin
        n_fail++;
        $display("FAIL rotate step %0d: edges=%0d leds=%b cycle=%b, expected 4 %b %b",
                 k, n, l, c, exp_l[k], exp_c[k]);
      end
    end
  endtask

  task automatic test_binary();
    int n; logic [3:0] l; logic c;
    logic [3:0] e;
    MODE = 2'd3;
    for (int k = 1; k <= 16; k++) begin
      wait_tick(n, l, c);
      e = (k == 16) ? 4'd1 : 4'(k);
      n_checks++;
      if (l !== e || c !== ((k == 1) || (k == 16))) begin
        n_fail++;
        $display("FAIL binary step %0d: leds=%b cycle=%b, expected %b %b",
                 k, l, c, e, ((k == 1) || (k == 16)));
      end
    end
  endtask

  task automatic test_enable();
    int n; logic [3:0] l; logic c;
    logic [3:0] held;
    logic       bad;
    MODE = 2'd1;
    wait_tick(n, l, c);
    for (int i = LAT; i < 2; i++) begin
      @(posedge CLK); #1;
    end
    held = LEDS;
    EN   = 1'b0;
    bad  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      if (LEDS !== held || TICK !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad !== 1'b0 || held !== 4'b0001) begin
      n_fail++;
      $display("FAIL enable_freeze: leds changed or tick seen while EN low (held=%b), expected frozen 0001", held);
    end
    EN   = 1'b1;
    skew = 0;
    wait_tick(n, l, c);
    n_checks++;
    if (n !== 2 || l !== 4'b0010 || c !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_resume: edges=%0d leds=%b cycle=%b, expected 2 0010 0", n, l, c);
    end
  endtask

  task automatic test_mode_change();
    int n; logic [3:0] l; logic c;
    logic [3:0] exp_l [0:6];
    logic       exp_c [0:6];
    exp_l = '{4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b0011, 4'b0111, 4'b1111};
    exp_c = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    MODE = 2'd0;
    for (int k = 0; k < 7; k++) begin
      if (k == 3) MODE = 2'd2;
      if (k == 5) begin
        MODE = 2'd3;
        @(posedge CLK); #1;
        MODE = 2'd2;
      end
      wait_tick(n, l, c);
      n_checks++;
      if (l !== exp_l[k] || c !== exp_c[k] || n == 0) begin
        n_fail++;
        $display("FAIL mode_change step %0d: edges=%0d leds=%b cycle=%b, expected %b %b",
                 k, n, l, c, exp_l[k], exp_c[k]);
      end
    end
  endtask

  task automatic test_async_reset();
    int n; logic [3:0] l; logic c;
    #2;
    RESETN = 1'b0;
    #1;
    n_checks++;
    if (LEDS !== 4'b0001 || TICK !== 1'b0 || CYCLE !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: leds=%b tick=%b cycle=%b, expected 0001 0 0", LEDS, TICK, CYCLE);
    end
    MODE = 2'd0;
    #20;
    RESETN = 1'b1;
    skew = 0;
    wait_tick(n, l, c);
    n_checks++;
    if (n !== 4 || l !== 4'b0010 || c !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: edges=%0d leds=%b cycle=%b, expected 4 0010 0", n, l, c);
    end
  endtask

`ifdef LED_PATTERN_PWM_EN
  task automatic test_pwm();
    int on_cnt;
    EN = 1'b0;
    RESETN = 1'b0;
    #7;
    RESETN = 1'b1;
    BRIGHT = 4'd3;
    repeat (2) @(posedge CLK);
    #1;
    on_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge CLK); #1;
      if (LEDS[0] === 1'b1) on_cnt++;
    end
    n_checks++;
    if (on_cnt !== 4) begin
      n_fail++;
      $display("FAIL pwm_bright3: led0 high %0d of 16 cycles, expected 4", on_cnt);
    end
    BRIGHT = 4'd15;
    repeat (2) @(posedge CLK);
    #1;
    on_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge CLK); #1;
      if (LEDS === 4'b0001) on_cnt++;
    end
    n_checks++;
    if (on_cnt !== 16) begin
      n_fail++;
      $display("FAIL pwm_bright15: led0 high %0d of 16 cycles, expected 16", on_cnt);
    end
  endtask
`endif

  initial begin
    RESETN = 1'b0;
    EN     = 1'b1;
    MODE   = 2'd0;
`ifdef LED_PATTERN_PWM_EN
    BRIGHT = 4'd15;
`endif
    test_reset();
    test_bounce();
    test_rotate();
    test_binary();
    test_enable();
    test_mode_change();
    test_async_reset();
`ifdef LED_PATTERN_PWM_EN
    test_pwm();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised LED animation engine: a prescaler turns the system clock into a pattern tick, and a small state machine steps an N-wide LED vector through one of four run-time-selectable patterns. It sits between the PLL-clocked system domain and the board LED pins of each ice40 top, and exports tick and cycle-start strobes for scope test points. It generalises the fixed 8-LED bounce sweep to any width, rate and pattern.

## Interface
- N_LEDS, 8: LED vector width; legal range 2..32.
- TICK_DIV, 6000000: system clocks per pattern tick; minimum 2.
- CLK  in  1  system clock (PLL global clock).
- RESETN  in  1  asynchronous active-low reset; the top drives it from PLL `locked`.
- EN  in  1  run enable; low freezes the prescaler and the pattern.
- MODE  in  2  pattern select: 0 bounce, 1 rotate, 2 bar fill, 3 binary count.
- BRIGHT  in  4  duty select; port exists only with LED_PATTERN_PWM_EN.
- LEDS  out  N_LEDS  LED drive, bit 0 = LED0.
- TICK  out  1  one-cycle strobe per pattern step.
- CYCLE  out  1  one-cycle strobe when the pattern re-enters its start state.

## Operation
- Prescaler: counter of width clog2(TICK_DIV) runs 0..TICK_DIV-1 while EN=1. At TICK_DIV-1 it wraps to 0 and a step occurs. EN=0 holds the count mid-period; there is no restart.
- Step state: pos (0..N_LEDS-1), dir (up/down), bin (N_LEDS bits), active mode amode.
- On each step, MODE is sampled. If MODE != amode: amode<=MODE, pos<=0, dir<=up, bin<=1, CYCLE pulses. No pattern advance occurs on that step.
- Otherwise amode advances as follows:
  - Bounce (0): pos moves 0→N-1→0, one-hot at bit pos. dir flips at both ends. Period 2N-2 steps. Endpoints are shown once.
  - Rotate (1): pos<=(pos+1) mod N, one-hot. Period N.
  - Bar (2): same traversal as bounce. LEDS = thermometer with bits [pos:0] set. Period 2N-2.
  - Binary (3): bin<=bin+1, wrapping 2^N-1 → 1 (all-off is skipped). LEDS=bin.
- CYCLE pulses on a step whose new state is the start state (pos=0 for modes 0-2, bin=1 for mode 3), and on a mode change. It does not pulse at reset.

## Timing
- Reset (asynchronous): prescaler=0, pos=0, dir=up, bin=1, amode=0, LEDS=N'b1, TICK=0, CYCLE=0.
- TICK, CYCLE and LEDS are all registered and update on the same edge. The first TICK is on the TICK_DIV-th rising edge after RESETN is released with EN=1.
- TICK period is exactly TICK_DIV cycles while EN=1. Each strobe is high for exactly 1 cycle.
- MODE is a quasi-static input, sampled only on step edges. Changes between steps have no effect until the next step.
- If RESETN is asserted mid-period or mid-pattern, all outputs go to reset values immediately, without waiting for a clock edge.

## Configuration
- LED_PATTERN_PWM_EN defined:
  - Adds the BRIGHT port and a free-running 4-bit pwm counter, which is reset to 0 and counts independently of EN.
  - LEDS <= pattern & {N{pwm <= BRIGHT}}, registered. This adds 1 cycle of latency relative to TICK.
  - Duty is (BRIGHT+1)/16, so BRIGHT=15 is always on.
  - LEDS reset value is N'b1.
- LED_PATTERN_PWM_EN undefined: no BRIGHT port and no pwm logic. LEDS is the pattern register directly.

## Test plan
- N=4, TICK_DIV=4, MODE=0: LEDS steps 0001,0010,0100,1000,0100,0010,0001 at 4-cycle intervals. CYCLE pulses on the return to 0001.
- N=4, MODE=1: 0001,0010,0100,1000,0001. CYCLE pulses with the 4th TICK. MODE=3: 1,2,…,15,1, with CYCLE on the wrap to 1.
- Toggle EN low for 10 cycles mid-period: TICK is delayed by exactly 10 cycles and LEDS does not change while EN is low.
- Change MODE 0→2 between steps with LEDS=0100: at the next TICK, LEDS=0001 and CYCLE=1. The following steps show 0011 and 0111.
- Assert RESETN low between clock edges: LEDS=0001 and TICK=CYCLE=0 with no clock edge. After release, the first TICK comes after TICK_DIV edges.
- PWM build, BRIGHT=3, pattern 0001: LED0 is high 4 of every 16 cycles. BRIGHT=15: LED0 is constantly high.
